// File: rtl/seq_detector_param.sv
// seq_detector_param: run-time configurable serial pattern detector.
// Latency: Mealy flag is combinational with the completing bit; Moore flag is
// registered one cycle after the completing bit; match_cnt updates on that edge.
// Backpressure: none. A bit is consumed on every edge where din_valid is high,
// except on a cfg_load edge, where the bit is dropped.
//
// Ports:
//   clk, rst     rising-edge clock, synchronous active-high reset
//   din          serial data bit, sampled when din_valid is high
//   din_valid    qualifies din; low cycles leave the history untouched
//   cfg_load     latch cfg_* and clear the bit history
//   cfg_pattern  pattern; bit [L-1] is received first, bit [0] last
//   cfg_len      pattern length L (0 disables, values above MAX_LEN clamp)
//   cfg_overlap  1 allows overlapping matches
//   cfg_mealy    1 = combinational flag, 0 = registered flag
//   clr_cnt      clear the match counter
//   flag         match indication
//   match_cnt    saturating match counter
module seq_detector_param #(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 8,
  localparam int LEN_W  = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               din,
  input  logic               din_valid,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               cfg_mealy,
  input  logic               clr_cnt,
  output logic               flag,
  output logic [CNT_W-1:0]   match_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(MAX_LEN);

  // Latched configuration
  logic [MAX_LEN-1:0] pat_q;
  logic [LEN_W-1:0]   len_q;
  logic               ovl_q;
  logic               mealy_q;

  // Bit history and number of valid bits seen since the last clear
  logic [MAX_LEN-1:0] hist;
  logic [LEN_W-1:0]   fill;

  logic               moore_q;
  logic [CNT_W-1:0]   cnt;

  logic [MAX_LEN-1:0] shifted;
  logic [MAX_LEN-1:0] mask;
  logic [LEN_W:0]     fill_inc;
  logic               cmp_ok;
  logic               match;
  logic [LEN_W-1:0]   len_clamped;

  always_comb begin
    // History as it would look after accepting the current bit; only the
    // low L positions take part in the comparison.
    shifted = {hist[MAX_LEN-2:0], din};
    mask    = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      mask[i] = (i < int'(len_q));
    end
    cmp_ok = (((shifted ^ pat_q) & mask) == '0);

    // One bit wider so that fill+1 cannot wrap when fill sits at MAX_LEN.
    fill_inc = {1'b0, fill} + (LEN_W + 1)'(1);

    // A load edge discards the bit, and reset overrides everything, so
    // neither may produce a match (this also keeps the Mealy flag low).
    match = din_valid && !cfg_load && !rst
            && (len_q != '0)
            && (fill_inc >= {1'b0, len_q})
            && cmp_ok;

    len_clamped = (cfg_len > LEN_MAX) ? LEN_MAX : cfg_len;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pat_q   <= '0;
      len_q   <= '0;
      ovl_q   <= 1'b1;
      mealy_q <= 1'b0;
      hist    <= '0;
      fill    <= '0;
      moore_q <= 1'b0;
      cnt     <= '0;
    end else begin
      // Counter is independent of configuration loads.
      if (clr_cnt) begin
        cnt <= match ? CNT_W'(1) : '0;
      end else if (match && (cnt != CNT_MAX)) begin
        cnt <= cnt + CNT_W'(1);
      end

      // match is already low on a load edge, so this also clears the
      // registered flag when the configuration changes.
      moore_q <= match;

      if (cfg_load) begin
        pat_q   <= cfg_pattern;
        len_q   <= len_clamped;
        ovl_q   <= cfg_overlap;
        mealy_q <= cfg_mealy;
        hist    <= '0;
        fill    <= '0;
      end else if (din_valid) begin
        hist <= shifted;
        // Without overlap the next match must be built from fresh bits, so
        // the fill count restarts; the history itself keeps shifting.
        if (match && !ovl_q) begin
          fill <= '0;
        end else if (fill != LEN_MAX) begin
          fill <= fill + LEN_W'(1);
        end
      end
    end
  end

  assign flag      = mealy_q ? match : moore_q;
  assign match_cnt = cnt;

endmodule
